cp_remove: RTL

- Receive-side cyclic-prefix removal stage; sits directly downstream of the CP insertion stage (CP_top) in the modem loopback chain.
- Consumes 14-bit signed I/Q samples framed by a start-of-symbol pulse, discards the first CP_LEN samples of each symbol, and forwards exactly N_FFT samples to the receive FFT.
- Forwarded samples are framed with sop/eop. The block reports symbol count and framing errors.

---
 rtl/cp_remove.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/cp_remove.sv
// Cyclic-prefix removal: drops the first CP_LEN samples of each sop-framed
// symbol, forwards the next N_FFT samples with sop/eop framing, counts
// completed symbols and flags early-sop framing errors (sticky).
module cp_remove #(
    parameter int WIDTH  = 14,
    parameter int N_FFT  = 64,
    parameter int CP_LEN = 16,
    parameter int CNT_W  = 7,
    parameter int SYM_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] in_i,
    input  logic signed [WIDTH-1:0] in_q,
    input  logic                    in_valid,
    input  logic                    sop_in,
    output logic signed [WIDTH-1:0] out_i,
    output logic signed [WIDTH-1:0] out_q,
    output logic                    out_valid,
    output logic                    sop_out,
    output logic                    eop_out,
    output logic [SYM_W-1:0]        sym_cnt,
    output logic                    err
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_PASS
    } state_t;

    localparam logic [CNT_W-1:0] LP_CP_LAST  = CNT_W'(CP_LEN - 1);
    localparam logic [CNT_W-1:0] LP_FFT_LAST = CNT_W'(N_FFT - 1);
    localparam logic [CNT_W-1:0] LP_ONE      = CNT_W'(1);

    // A one-sample prefix means the sop sample alone is the whole CP,
    // so the symbol start jumps straight into the pass phase.
    localparam state_t           LP_SOP_STATE = (CP_LEN == 1) ? ST_PASS : ST_SKIP;
    localparam logic [CNT_W-1:0] LP_SOP_CNT   = (CP_LEN == 1) ? '0 : LP_ONE;

    state_t           r_state;
    state_t           w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             w_fwd;
    logic             w_sop;
    logic             w_eop;
    logic             w_err_set;

    // State and sample counter; everything freezes while en is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else if (en) begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
        end
    end

    // Next-state, counter and per-sample framing decisions.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_fwd     = 1'b0;
        w_sop     = 1'b0;
        w_eop     = 1'b0;
        w_err_set = 1'b0;
        if (in_valid) begin
            if (sop_in) begin
                // A sop always restarts the symbol; outside IDLE it also
                // abandons the current one and is a framing error.
                w_err_set = (r_state != ST_IDLE);
                w_state_n = LP_SOP_STATE;
                w_cnt_n   = LP_SOP_CNT;
            end else begin
                case (r_state)
                    ST_SKIP: begin
                        if (r_cnt == LP_CP_LAST) begin
                            w_state_n = ST_PASS;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt + LP_ONE;
                        end
                    end
                    ST_PASS: begin
                        w_fwd = 1'b1;
                        w_sop = (r_cnt == '0);
                        w_eop = (r_cnt == LP_FFT_LAST);
                        if (r_cnt == LP_FFT_LAST) begin
                            w_state_n = ST_IDLE;
                            w_cnt_n   = '0;
                        end else begin
                            w_cnt_n = r_cnt + LP_ONE;
                        end
                    end
                    default: begin
                        w_state_n = ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Registered output stage: one cycle latency, data holds when idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_i     <= '0;
            out_q     <= '0;
            out_valid <= 1'b0;
            sop_out   <= 1'b0;
            eop_out   <= 1'b0;
        end else if (en) begin
            out_valid <= w_fwd;
            sop_out   <= w_sop;
            eop_out   <= w_eop;
            if (w_fwd) begin
                out_i <= in_i;
                out_q <= in_q;
            end
        end
    end

    // Completed-symbol counter and sticky framing-error flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sym_cnt <= '0;
            err     <= 1'b0;
        end else if (en) begin
            if (w_eop) begin
                sym_cnt <= sym_cnt + SYM_W'(1);
            end
            if (w_err_set) begin
                err <= 1'b1;
            end
        end
    end

endmodule
